// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM state encoding for the SPI NOR flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDID      = 8'h9F;
  localparam logic [7:0] CMD_PD        = 8'hB9;
  localparam logic [7:0] CMD_RPD       = 8'hAB;
  localparam logic [7:0] CMD_RESET     = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StId,
    StIgnore
  } state_e;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives edge strobes.
module spi_pin_sync (
  input  logic clk_i,
  input  logic csb_i,
  input  logic sclk_i,
  input  logic mosi_i,
  output logic csb_s_o,
  output logic csb_fall_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic mosi_s_o
);

  logic [2:0] csb_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;

  // Deliberately unreset: the chain keeps tracking the pins through reset, so a
  // chip select already low at reset release never shows up as a falling edge.
  always_ff @(posedge clk_i) begin
    csb_q  <= {csb_q[1:0], csb_i};
    sclk_q <= {sclk_q[1:0], sclk_i};
    mosi_q <= {mosi_q[0], mosi_i};
  end

  assign csb_s_o     = csb_q[1];
  assign csb_fall_o  = ~csb_q[1] & csb_q[2];
  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
  assign mosi_s_o    = mosi_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR flash emulator (mode 0, single I/O) serving reads from a synchronous byte memory.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter int unsigned DUMMY_BITS = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flash_csb,
  input  logic                 flash_clk,
  input  logic                 flash_io0_di,
  output logic                 flash_io1_do,
  output logic                 flash_io1_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 powered_down,
  output logic                 busy
);

  localparam int unsigned    CntW      = 6;
  localparam logic [CntW-1:0] LastDummy = CntW'(DUMMY_BITS - 1);

  logic csb_s, csb_fall, sclk_rise, sclk_fall, mosi_s;

  spi_pin_sync u_sync (
    .clk_i       (clk),
    .csb_i       (flash_csb),
    .sclk_i      (flash_clk),
    .mosi_i      (flash_io0_di),
    .csb_s_o     (csb_s),
    .csb_fall_o  (csb_fall),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .mosi_s_o    (mosi_s)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      tx_q, tx_d;
  logic [23:0]     addr_q, addr_d;
  logic [1:0]      id_idx_q, id_idx_d;
  logic            fast_q, fast_d;
  logic            pd_q, pd_d;
  logic            oe_q, oe_d;
  logic            do_q, do_d;
  logic            mem_re_q, mem_re_d;
  logic            load_q, load_d;
  logic [7:0]      op;
  logic [7:0]      id_byte;

  always_comb begin
    unique case (id_idx_q)
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    id_idx_d  = id_idx_q;
    fast_d    = fast_q;
    pd_d      = pd_q;
    oe_d      = oe_q;
    do_d      = do_q;
    mem_re_d  = 1'b0;
    load_d    = mem_re_q;
    op        = {rx_q[6:0], mosi_s};

    // Released chip select beats any concurrent sclk edge.
    if (csb_s) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      do_d      = 1'b0;
      load_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (csb_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
            fast_d    = 1'b0;
          end
        end
        StCmd: begin
          if (sclk_rise) begin
            rx_d      = op;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(7)) begin
              bit_cnt_d = '0;
              state_d   = StIgnore;
              if (!pd_q || op == CMD_RPD) begin
                case (op)
                  CMD_READ:      state_d = StAddr;
                  CMD_FAST_READ: begin
                    state_d = StAddr;
                    fast_d  = 1'b1;
                  end
                  CMD_RDID: begin
                    state_d  = StId;
                    tx_d     = JEDEC_ID[23:16];
                    id_idx_d = 2'd1;
                  end
                  CMD_PD:        pd_d = 1'b1;
                  CMD_RPD:       pd_d = 1'b0;
                  CMD_RESET:     state_d = StIgnore;
                  default:       state_d = StIgnore;
                endcase
              end
            end
          end
        end
        StAddr: begin
          if (sclk_rise) begin
            addr_d    = {addr_q[22:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(23)) begin
              bit_cnt_d = '0;
              if (fast_q) begin
                state_d = StDummy;
              end else begin
                state_d  = StData;
                mem_re_d = 1'b1;
              end
            end
          end
        end
        StDummy: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastDummy) begin
              bit_cnt_d = '0;
              state_d   = StData;
              mem_re_d  = 1'b1;
            end
          end
        end
        StData, StId: begin
          if (load_q && state_q == StData) begin
            tx_d = mem_rdata;
          end
          if (sclk_fall) begin
            oe_d      = 1'b1;
            do_d      = tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Bit 0 just went out: fetch the next byte well before the next falling edge.
            if (bit_cnt_q == CntW'(7)) begin
              bit_cnt_d = '0;
              if (state_q == StData) begin
                addr_d   = addr_q + 24'd1;
                mem_re_d = 1'b1;
              end else begin
                tx_d = id_byte;
                if (id_idx_q != 2'd3) begin
                  id_idx_d = id_idx_q + 2'd1;
                end
              end
            end
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      id_idx_q  <= '0;
      fast_q    <= 1'b0;
      pd_q      <= 1'b0;
      oe_q      <= 1'b0;
      do_q      <= 1'b0;
      mem_re_q  <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      id_idx_q  <= id_idx_d;
      fast_q    <= fast_d;
      pd_q      <= pd_d;
      oe_q      <= oe_d;
      do_q      <= do_d;
      mem_re_q  <= mem_re_d;
      load_q    <= load_d;
    end
  end

  assign flash_io1_do = do_q;
  assign flash_io1_oe = oe_q;
  assign mem_addr     = addr_q[ADDR_BITS-1:0];
  assign mem_re       = mem_re_q;
  assign powered_down = pd_q;
  assign busy         = resetn & ~csb_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: stimulus queues expected MISO bytes and memory addresses, monitors compare.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flash_csb = 1'b1;
  logic        flash_clk = 1'b0;
  logic        flash_io0_di = 1'b0;
  logic        flash_io1_do;
  logic        flash_io1_oe;
  logic [23:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        powered_down;
  logic        busy;

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk          (clk),
    .resetn       (resetn),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io0_di (flash_io0_di),
    .flash_io1_do (flash_io1_do),
    .flash_io1_oe (flash_io1_oe),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .powered_down (powered_down),
    .busy         (busy)
  );

  logic [7:0] mem [int];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
  end

  int          checks = 0;
  int          errors = 0;
  int          re_cnt = 0;
  int          oe_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // MISO monitor: samples on sclk rise like the initiator, one byte at a time.
  initial begin : mon_miso
    logic [7:0] sh;
    int n;
    sh = 8'h00;
    n = 0;
    forever begin
      @(posedge flash_clk or posedge flash_csb);
      if (flash_csb) begin
        n = 0;
      end else if (flash_io1_oe) begin
        sh = {sh[6:0], flash_io1_do};
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_extra: got %h expected no byte", sh);
          end else begin
            check("miso_byte", {24'h0, sh}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // Memory-port monitor.
  always @(negedge clk) begin
    if (flash_io1_oe) oe_cnt++;
    if (mem_re) begin
      re_cnt++;
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_re_extra: got addr %h expected no read", mem_addr);
      end else begin
        check("mem_addr", {8'h0, mem_addr}, {8'h0, exp_addr_q.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    flash_io0_di = b;
    wait_clk(HALF);
    flash_clk = 1'b1;
    wait_clk(HALF);
    flash_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    flash_csb = 1'b0;
    wait_clk(2);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    flash_csb = 1'b1;
    wait_clk(4 * HALF);
  endtask

  task automatic read_hdr(input logic [7:0] opc, input logic [23:0] a);
    send_byte(opc);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic data_bytes(input int n);
    for (int i = 0; i < n * 8; i++) spi_bit(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_do"}, {31'h0, flash_io1_do}, 32'h0);
    check({tag, "_oe"}, {31'h0, flash_io1_oe}, 32'h0);
    check({tag, "_re"}, {31'h0, mem_re}, 32'h0);
    check({tag, "_addr"}, {8'h0, mem_addr}, 32'h0);
    check({tag, "_pd"}, {31'h0, powered_down}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin : stim
    int oe0;
    int re0;
    mem[32'h100] = 8'hA5;
    mem[32'h101] = 8'h5A;
    mem[32'h102] = 8'h01;
    mem[32'h103] = 8'hFE;
    mem[32'h010] = 8'h11;
    mem[32'h011] = 8'h22;
    mem[32'hFFFFFF] = 8'h77;
    mem[32'h000] = 8'h88;

    wait_clk(5);
    check_reset_outputs("reset");
    resetn = 1'b1;
    wait_clk(4);

    // Plain read of four bytes at 0x100.
    exp_q = '{8'hA5, 8'h5A, 8'h01, 8'hFE};
    exp_addr_q = '{24'h100, 24'h101, 24'h102, 24'h103, 24'h104};
    oe0 = oe_cnt;
    cs_low();
    check("busy_active", {31'h0, busy}, 32'h1);
    read_hdr(8'h03, 24'h000100);
    check("oe_before_data", oe_cnt - oe0, 0);
    data_bytes(4);
    cs_high();

    // Fast read: no memory access until every dummy bit has been clocked.
    exp_q = '{8'h11, 8'h22};
    exp_addr_q = '{24'h010, 24'h011, 24'h012};
    re0 = re_cnt;
    cs_low();
    read_hdr(8'h0B, 24'h000010);
    for (int i = 0; i < 7; i++) spi_bit(1'b0);
    check("no_re_in_dummy", re_cnt - re0, 0);
    spi_bit(1'b0);
    data_bytes(2);
    cs_high();

    // JEDEC ID then zero fill, memory untouched.
    exp_q = '{8'hEF, 8'h40, 8'h16, 8'h00};
    re0 = re_cnt;
    cs_low();
    send_byte(8'h9F);
    data_bytes(4);
    cs_high();
    check("rdid_no_re", re_cnt - re0, 0);

    // Address wrap at the top of the space.
    exp_q = '{8'h77, 8'h88};
    exp_addr_q = '{24'hFFFFFF, 24'h000000, 24'h000001};
    cs_low();
    read_hdr(8'h03, 24'hFFFFFF);
    data_bytes(2);
    cs_high();

    // Deep power-down blocks reads until release.
    cs_low();
    send_byte(8'hB9);
    cs_high();
    check("pd_set", {31'h0, powered_down}, 32'h1);
    oe0 = oe_cnt;
    re0 = re_cnt;
    cs_low();
    read_hdr(8'h03, 24'h000000);
    data_bytes(1);
    cs_high();
    check("pd_no_oe", oe_cnt - oe0, 0);
    check("pd_no_re", re_cnt - re0, 0);
    check("pd_still", {31'h0, powered_down}, 32'h1);
    cs_low();
    send_byte(8'hAB);
    cs_high();
    check("pd_clear", {31'h0, powered_down}, 32'h0);
    exp_q = '{8'hA5};
    exp_addr_q = '{24'h100, 24'h101};
    cs_low();
    read_hdr(8'h03, 24'h000100);
    data_bytes(1);
    cs_high();

    // Chip select released halfway through a data byte.
    exp_addr_q = '{24'h100};
    cs_low();
    read_hdr(8'h03, 24'h000100);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    check("oe_mid_byte", {31'h0, flash_io1_oe}, 32'h1);
    flash_csb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_oe", {31'h0, flash_io1_oe}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    wait_clk(4 * HALF);

    // Reset in the middle of the address phase.
    cs_low();
    send_byte(8'h03);
    send_byte(8'hFF);
    wait_clk(2);
    resetn = 1'b0;
    wait_clk(3);
    check_reset_outputs("midreset");
    resetn = 1'b1;
    wait_clk(3);
    oe0 = oe_cnt;
    re0 = re_cnt;
    send_byte(8'hFF);
    send_byte(8'h00);
    data_bytes(1);
    cs_high();
    check("post_reset_no_oe", oe_cnt - oe0, 0);
    check("post_reset_no_re", re_cnt - re0, 0);
    exp_q = '{8'h5A};
    exp_addr_q = '{24'h101, 24'h102};
    cs_low();
    read_hdr(8'h03, 24'h000101);
    data_bytes(1);
    cs_high();

    check("miso_drained", exp_q.size(), 0);
    check("addr_drained", exp_addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
